// File: rtl/std_divmod_pkg.sv
// Shared types and sign helpers for the sequential divider.
// Helpers work at the widest legal width; callers cast the result back down.
package std_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Two's-complement magnitude; the caller supplies the sign bit of its own width.
  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v, input logic sign);
    return cond_negate(v, sign);
  endfunction

endpackage

// File: rtl/std_divmod_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module std_divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remainder_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {remainder_in, dividend_msb};
  assign diff    = shifted - {1'b0, divisor};

  // shifted < 2*divisor, so the top bit of diff is set exactly when the subtract borrows.
  assign q_bit         = ~diff[WIDTH];
  assign remainder_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/std_divmod_seq.sv
// Iterative restoring divider: quotient and remainder in WIDTH+1 cycles, go/done handshake,
// optional signed mode with truncation toward zero.
module std_divmod_seq
  import std_divmod_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;      // dividend shifts out the top while quotient bits enter the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] left_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;

  logic             accept;
  logic             last_step;
  logic             left_neg;
  logic             right_neg;
  logic [WIDTH-1:0] left_mag;
  logic [WIDTH-1:0] right_mag;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] dq_nx;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  assign accept    = go && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (cnt_q == CW'(1));

  assign left_neg  = (SIGNED != 0) && left[WIDTH-1];
  assign right_neg = (SIGNED != 0) && right[WIDTH-1];
  assign left_mag  = WIDTH'(magnitude(64'(left), left_neg));
  assign right_mag = WIDTH'(magnitude(64'(right), right_neg));

  std_divmod_step #(.WIDTH(WIDTH)) u_step (
    .remainder_in (rem_q),
    .dividend_msb (dq_q[WIDTH-1]),
    .divisor      (dvs_q),
    .remainder_out(rem_nx),
    .q_bit        (q_bit)
  );

  assign dq_nx   = {dq_q[WIDTH-2:0], q_bit};
  assign quo_res = WIDTH'(cond_negate(64'(dq_nx), neg_quo_q));
  assign rem_res = WIDTH'(cond_negate(64'(rem_nx), neg_rem_q));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = RUN;
      RUN:     if (cnt_q == CW'(1)) state_next = DONE;
      DONE:    state_next = go ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q         <= '0;
      dq_q          <= '0;
      dvs_q         <= '0;
      left_q        <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      div0_q        <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (accept) begin
      rem_q     <= '0;
      dq_q      <= left_mag;
      dvs_q     <= right_mag;
      left_q    <= left;
      cnt_q     <= CW'(WIDTH);
      neg_quo_q <= left_neg ^ right_neg;
      neg_rem_q <= left_neg;
      div0_q    <= (right == '0);
    end else if (state == RUN) begin
      rem_q <= rem_nx;
      dq_q  <= dq_nx;
      cnt_q <= cnt_q - CW'(1);
      if (last_step) begin
        if (div0_q) begin
          out_quotient  <= '1;
          out_remainder <= left_q;
        end else begin
          out_quotient  <= quo_res;
          out_remainder <= rem_res;
        end
      end
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_std_divmod_seq.sv
// Runs unsigned and signed 8-bit dividers side by side against an integer-arithmetic model.
module tb_std_divmod_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [W-1:0] uq, ur, sq, sr;
  logic         udone, sdone;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  std_divmod_seq #(.WIDTH(W), .SIGNED(0)) u_uns (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out_quotient(uq), .out_remainder(ur), .done(udone)
  );

  std_divmod_seq #(.WIDTH(W), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out_quotient(sq), .out_remainder(sr), .done(sdone)
  );

  function automatic void model(input logic [W-1:0] l, input logic [W-1:0] r, input bit sgn,
                                output logic [W-1:0] q, output logic [W-1:0] rm);
    int a, b, qi, ri;
    if (r == '0) begin
      q  = '1;
      rm = l;
    end else if (!sgn) begin
      q  = l / r;
      rm = l % r;
    end else begin
      a  = $signed(l);
      b  = $signed(r);
      qi = a / b;
      ri = a % b;
      q  = qi[W-1:0];
      rm = ri[W-1:0];
    end
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W-1:0] eq, er;
    model(l, r, 1'b0, eq, er);
    chk({tag, " uq"}, uq, eq);
    chk({tag, " ur"}, ur, er);
    model(l, r, 1'b1, eq, er);
    chk({tag, " sq"}, sq, eq);
    chk({tag, " sr"}, sr, er);
  endtask

  // One go pulse; optional junk go pulses during RUN; done expected exactly W+1 cycles later.
  task automatic run_op(input string tag, input logic [W-1:0] l, input logic [W-1:0] r, input bit noise);
    int lat;
    go = 1'b1; left = l; right = r;
    tick();
    go = 1'b0;
    left = W'($urandom); right = W'($urandom);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) tick();
      if (udone) begin lat = k; break; end
      go = (noise && k <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk({tag, " latency"}, W'(lat), W'(W + 1));
    chk({tag, " sdone"}, {7'b0, sdone}, 8'd1);
    check_results(tag, l, r);
    go = 1'b0;
    tick();
    chk({tag, " done drop"}, {6'b0, udone, sdone}, 8'd0);
    check_results({tag, " hold"}, l, r);
  endtask

  initial begin
    logic [W-1:0] ops_l [3];
    logic [W-1:0] ops_r [3];
    logic [W-1:0] rl, rr;
    int pulses;

    reset = 1'b1; go = 1'b0; left = '0; right = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst udone", {7'b0, udone}, 8'd0);
    chk("rst sdone", {7'b0, sdone}, 8'd0);
    chk("rst uq", uq, 8'd0);
    chk("rst ur", ur, 8'd0);
    chk("rst sq", sq, 8'd0);
    chk("rst sr", sr, 8'd0);

    run_op("200/7",    8'd200,  8'd7,    1'b0);
    run_op("-7/2",     8'hF9,   8'd2,    1'b0);
    run_op("7/-2",     8'd7,    8'hFE,   1'b1);
    run_op("div0",     8'h35,   8'h00,   1'b0);
    run_op("ovf",      8'h80,   8'hFF,   1'b1);
    run_op("0/0",      8'h00,   8'h00,   1'b0);
    run_op("ff/80",    8'hFF,   8'h80,   1'b0);

    for (int i = 0; i < 20; i++) begin
      rl = W'($urandom);
      rr = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      run_op($sformatf("rnd%0d", i), rl, rr, 1'b1);
    end

    // go held high: back-to-back operations, one result every W+1 cycles
    ops_l = '{8'd100, 8'd255, 8'd0};
    ops_r = '{8'd10,  8'd1,   8'd3};
    go = 1'b1; left = ops_l[0]; right = ops_r[0];
    tick();
    for (int k = 1; k <= 3 * (W + 1); k++) begin
      if (k > 1) tick();
      if (k == 1)           begin left = ops_l[1]; right = ops_r[1]; end
      if (k == W + 2)       begin left = ops_l[2]; right = ops_r[2]; end
      if (k == 2 * W + 3)   go = 1'b0;
      chk($sformatf("b2b done c%0d", k), {6'b0, udone, sdone},
          (k % (W + 1) == 0) ? 8'd3 : 8'd0);
      if (k % (W + 1) == 0)
        check_results($sformatf("b2b op%0d", k / (W + 1)), ops_l[k / (W + 1) - 1], ops_r[k / (W + 1) - 1]);
    end
    tick();
    chk("b2b idle", {6'b0, udone, sdone}, 8'd0);

    // reset in the middle of RUN discards the operation and clears the outputs
    run_op("pre-rst", 8'd77, 8'd5, 1'b0);
    go = 1'b1; left = 8'd200; right = 8'd7;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst done", {6'b0, udone, sdone}, 8'd0);
    chk("midrst uq", uq, 8'd0);
    chk("midrst ur", ur, 8'd0);
    chk("midrst sq", sq, 8'd0);
    chk("midrst sr", sr, 8'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (udone || sdone) pulses++;
    end
    chk("midrst no done", W'(pulses), 8'd0);
    chk("midrst uq hold", uq, 8'd0);
    run_op("post-rst", 8'd200, 8'd7, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
